// File: rtl/fma_pkg.sv
// fma_pkg: shared types, limits and FSM states for the FMA dot-product sequencer
package fma_pkg;
  typedef logic [31:0] w_t;
  typedef logic [15:0] opr_t;
  typedef struct packed {
    opr_t m;
    opr_t x;
    opr_t c;
  } trip_t;
  localparam int LEN_W = 5;
  localparam int MAX_LEN = 16;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, WAIT} state_t;
endpackage

// File: rtl/fma_seq_fifo.sv
// fma_seq_fifo: count-based operand FIFO with simultaneous push/pop
//   push_i/din_i  write one triple (caller guarantees !full_o)
//   pop_i         drop the head (caller guarantees !empty_o)
//   head_o        current head, zero when empty
//   full_o/empty_o occupancy flags
module fma_seq_fifo
  import fma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  logic  pop_i,
  input  trip_t din_i,
  output trip_t head_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int AW = $clog2(DEPTH);
  trip_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = empty_o ? '0 : mem_q[rp_q];
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
endmodule

// File: rtl/fma_dot_sequencer.sv
// fma_dot_sequencer: sequences one accumulator load and N operand passes into an external FMA, then returns its sum
//   cmd_*      command in (len beats, accumulator seed)
//   opr_*      operand triples in, buffered in fma_seq_fifo
//   fma_*      drive the FMA load and operand ports, fma_y is its accumulated sum
//   res_*      result out, held until accepted
//   busy       FSM not idle
//   stall_cnt  STREAM cycles with empty buffer, present only with FMA_SEQ_STALL_CNT_EN
module fma_dot_sequencer
  import fma_pkg::*;
#(
  parameter int OPR_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [LEN_W-1:0] cmd_len,
  input  w_t               cmd_init,
  input  logic             opr_vld,
  output logic             opr_rdy,
  input  opr_t             opr_m,
  input  opr_t             opr_x,
  input  opr_t             opr_c,
  output logic             fma_cntrl_load,
  output w_t               fma_cntrl_init,
  output logic             fma_pass,
  output opr_t             fma_m,
  output opr_t             fma_x,
  output opr_t             fma_c,
  input  w_t               fma_y,
  output logic             res_vld,
  input  logic             res_rdy,
  output w_t               res_y,
  output logic             busy
`ifdef FMA_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  state_t state_q;
  logic [LEN_W-1:0] cnt_q, len_d;
  w_t init_q, res_y_q;
  logic load_q, res_vld_q, res_vld_d, full, empty, accept;
  trip_t head;
  assign len_d = cmd_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;
  assign cmd_rdy = state_q == IDLE && (!res_vld_q || res_rdy);
  assign accept = cmd_vld && cmd_rdy;
  assign fma_pass = state_q == STREAM && !empty;
  // a WAIT capture wins over a same-cycle drain of the previous result
  assign res_vld_d = state_q == WAIT || (res_vld_q && !res_rdy);
  assign opr_rdy = !full;
  assign busy = state_q != IDLE;
  assign fma_cntrl_load = load_q;
  assign fma_cntrl_init = init_q;
  assign res_vld = res_vld_q;
  assign res_y = res_y_q;
  assign {fma_m, fma_x, fma_c} = head;
  fma_seq_fifo #(.DEPTH(OPR_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (opr_vld && opr_rdy),
    .pop_i  (fma_pass),
    .din_i  ('{m: opr_m, x: opr_x, c: opr_c}),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      init_q <= '0;
      load_q <= 1'b0;
      res_vld_q <= 1'b0;
      res_y_q <= '0;
    end else begin
      res_vld_q <= res_vld_d;
      load_q <= accept;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= LOAD;
          cnt_q <= len_d;
          init_q <= cmd_init;
        end
        LOAD: state_q <= cnt_q == '0 ? WAIT : STREAM;
        STREAM: if (fma_pass) begin
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_q <= WAIT;
        end
        WAIT: begin
          state_q <= IDLE;
          res_y_q <= fma_y;
        end
        default: state_q <= IDLE;
      endcase
    end
`ifdef FMA_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (accept) stall_cnt <= '0;
    else if (state_q == STREAM && empty && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fma_dot_sequencer.sv
// tb_fma_dot_sequencer: scoreboard bench for fma_dot_sequencer with an accumulating FMA model
module tb_fma_dot_sequencer;
  import fma_pkg::*;
  typedef struct {
    w_t y;
    int t;
  } exp_t;
  logic clk, rst_n, cmd_vld, cmd_rdy, opr_vld, opr_rdy, fma_cntrl_load, fma_pass, res_vld, res_rdy, busy;
  logic [4:0] cmd_len;
  w_t cmd_init, fma_cntrl_init, fma_y, res_y, acc;
  opr_t opr_m, opr_x, opr_c, fma_m, fma_x, fma_c;
`ifdef FMA_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int tests, fails, cyc, rise, win_len, win_cur, win_pass, win_gap, t, t2, c0, len, n, k;
  logic seen, win_on, rnd_rdy, rdy_fix;
  exp_t exp_q[$];
  exp_t e;
  w_t init, y;
  opr_t am[16], ax[16], ac[16];

  fma_dot_sequencer #(.OPR_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_len(cmd_len), .cmd_init(cmd_init),
    .opr_vld(opr_vld), .opr_rdy(opr_rdy), .opr_m(opr_m), .opr_x(opr_x), .opr_c(opr_c),
    .fma_cntrl_load(fma_cntrl_load), .fma_cntrl_init(fma_cntrl_init), .fma_pass(fma_pass),
    .fma_m(fma_m), .fma_x(fma_x), .fma_c(fma_c), .fma_y(fma_y),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_y(res_y), .busy(busy)
`ifdef FMA_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // downstream FMA: accumulator seeded by load, adds m*x+c on each pass
  always @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (fma_cntrl_load) acc <= fma_cntrl_init;
    else if (fma_pass) acc <= acc + w_t'(fma_m) * w_t'(fma_x) + w_t'(fma_c);
  assign fma_y = acc;

  initial forever begin
    @(posedge clk);
    #1;
    res_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] ex);
    tests++;
    if (a !== ex) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, a, ex);
    end
  endtask

  // monitor: pops the scoreboard on every result transfer, tracks pass/gap windows
  initial begin
    seen = 0;
    win_on = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        win_on = 0;
      end else begin
        if (fma_cntrl_load) begin
          chk("load_pass_excl", {31'b0, fma_pass}, 0);
          win_cur = win_len;
          win_on = win_len > 0;
          win_pass = 0;
          win_gap = 0;
        end else if (win_on) begin
          if (fma_pass) win_pass++;
          else win_gap++;
          if (win_pass == win_cur) win_on = 0;
        end
        if (res_vld && !seen) begin
          rise = cyc;
          seen = 1;
        end
        if (res_vld && res_rdy) begin
          chk("exp_available", {31'b0, exp_q.size() != 0}, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_y", res_y, e.y);
            if (e.t >= 0) chk("latency", rise, e.t);
          end
          seen = 0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [4:0] l, input w_t i, output int tc);
    int kk = 0;
    cmd_len = l;
    cmd_init = i;
    cmd_vld = 1;
    @(negedge clk);
    while (!cmd_rdy && kk < 1000) begin
      @(negedge clk);
      kk++;
    end
    chk("cmd_accept_timeout", {31'b0, cmd_rdy}, 1);
    tc = cyc;
    @(posedge clk);
    #1 cmd_vld = 0;
  endtask

  task automatic push_opr(input opr_t m, input opr_t x, input opr_t c);
    int kk = 0;
    opr_m = m;
    opr_x = x;
    opr_c = c;
    opr_vld = 1;
    @(negedge clk);
    while (!opr_rdy && kk < 1000) begin
      @(negedge clk);
      kk++;
    end
    chk("opr_push_timeout", {31'b0, opr_rdy}, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int kk = 0;
    while ((exp_q.size() != 0 || busy || res_vld) && kk < 3000) begin
      @(negedge clk);
      kk++;
    end
    chk("drain_timeout", {31'b0, kk < 3000}, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rnd_rdy = 0;
    rdy_fix = 1;
    rst_n = 0;
    cmd_vld = 0;
    cmd_len = 0;
    cmd_init = 0;
    opr_vld = 0;
    opr_m = 0;
    opr_x = 0;
    opr_c = 0;
    win_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_res_vld", {31'b0, res_vld}, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_load", {31'b0, fma_cntrl_load}, 0);
    chk("rst_pass", {31'b0, fma_pass}, 0);
    chk("rst_init", fma_cntrl_init, 0);
    chk("rst_opr_rdy", {31'b0, opr_rdy}, 1);
    chk("rst_cmd_rdy", {31'b0, cmd_rdy}, 1);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    // single beat
    push_opr(3, 4, 5);
    opr_vld = 0;
    win_len = 1;
    send_cmd(1, 0, t);
    exp_q.push_back('{32'd17, t + 4});
    @(negedge clk);
    chk("l1_load", {31'b0, fma_cntrl_load}, 1);
    chk("l1_init", fma_cntrl_init, 0);
    chk("l1_head", {fma_m, fma_x}, {16'd3, 16'd4});
    chk("l1_head_c", {16'b0, fma_c}, 5);
    @(negedge clk);
    chk("l1_pass", {31'b0, fma_pass}, 1);
    wait_idle();
    chk("l1_passes", win_pass, 1);
`ifdef FMA_SEQ_STALL_CNT_EN
    chk("l1_stall", {16'b0, stall_cnt}, 0);
`endif
    // zero beats
    win_len = 0;
    send_cmd(0, 32'h1234, t);
    exp_q.push_back('{32'h1234, t + 3});
    @(negedge clk);
    chk("l0_load", {31'b0, fma_cntrl_load}, 1);
    chk("l0_init", fma_cntrl_init, 32'h1234);
    @(negedge clk);
    chk("l0_nopass", {31'b0, fma_pass}, 0);
    wait_idle();
    // three beats back to back
    push_opr(2, 3, 1);
    push_opr(4, 5, 0);
    push_opr(1, 1, 1);
    opr_vld = 0;
    win_len = 3;
    send_cmd(3, 10, t);
    exp_q.push_back('{32'd39, t + 6});
    @(negedge clk);
    chk("l3_load", {31'b0, fma_cntrl_load}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l3_pass", {31'b0, fma_pass}, 1);
    end
    @(negedge clk);
    chk("l3_wait_nopass", {31'b0, fma_pass}, 0);
    wait_idle();
    // result backpressure and same-cycle re-accept
    rdy_fix = 0;
    @(posedge clk);
    #1;
    win_len = 0;
    send_cmd(0, 32'hABCD, t);
    exp_q.push_back('{32'hABCD, t + 3});
    k = 0;
    while (!res_vld && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_res_y", res_y, 32'hABCD);
      chk("hold_res_vld", {31'b0, res_vld}, 1);
      chk("hold_cmd_rdy", {31'b0, cmd_rdy}, 0);
    end
    @(posedge clk);
    rdy_fix = 1;
    #1;
    c0 = cyc;
    send_cmd(0, 32'h55, t2);
    chk("same_cycle_accept", t2, c0);
    exp_q.push_back('{32'h55, t2 + 3});
    wait_idle();
    // five operands into a four-deep buffer
    y = 32'd7;
    for (int i = 0; i < 5; i++) begin
      am[i] = opr_t'($urandom);
      ax[i] = opr_t'($urandom);
      ac[i] = opr_t'($urandom);
      y = y + w_t'(am[i]) * w_t'(ax[i]) + w_t'(ac[i]);
    end
    for (int i = 0; i < 4; i++) push_opr(am[i], ax[i], ac[i]);
    opr_vld = 0;
    @(negedge clk);
    chk("full_opr_rdy", {31'b0, opr_rdy}, 0);
    @(posedge clk);
    #1;
    win_len = 5;
    fork
      begin
        send_cmd(5, 32'd7, t);
        exp_q.push_back('{y, t + 8});
      end
      begin
        push_opr(am[4], ax[4], ac[4]);
        opr_vld = 0;
      end
    join
    wait_idle();
    chk("l5_passes", win_pass, 5);
    // reset in the middle of STREAM
    push_opr(1, 2, 3);
    push_opr(4, 5, 6);
    opr_vld = 0;
    win_len = 4;
    send_cmd(4, 32'h99, t);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_pass", {31'b0, fma_pass}, 0);
    chk("mrst_load", {31'b0, fma_cntrl_load}, 0);
    chk("mrst_init", fma_cntrl_init, 0);
    chk("mrst_res_vld", {31'b0, res_vld}, 0);
    chk("mrst_head", {16'b0, fma_m}, 0);
    chk("mrst_opr_rdy", {31'b0, opr_rdy}, 1);
`ifdef FMA_SEQ_STALL_CNT_EN
    chk("mrst_stall", {16'b0, stall_cnt}, 0);
`endif
    @(negedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    push_opr(6, 7, 8);
    opr_vld = 0;
    win_len = 1;
    send_cmd(1, 32'h100, t);
    exp_q.push_back('{32'h100 + 32'd50, t + 4});
    wait_idle();
    // randomized commands, operand gaps and result backpressure
    rnd_rdy = 1;
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 20);
      n = len > 16 ? 16 : len;
      init = $urandom;
      y = init;
      for (int i = 0; i < n; i++) begin
        am[i] = opr_t'($urandom);
        ax[i] = opr_t'($urandom);
        ac[i] = opr_t'($urandom);
        y = y + w_t'(am[i]) * w_t'(ax[i]) + w_t'(ac[i]);
      end
      win_len = n;
      fork
        begin
          send_cmd(5'(len), init, t);
          exp_q.push_back('{y, -1});
        end
        begin
          for (int i = 0; i < n; i++) begin
            push_opr(am[i], ax[i], ac[i]);
            if ($urandom_range(0, 2) == 0) begin
              opr_vld = 0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
          end
          opr_vld = 0;
        end
      join
      wait_idle();
      chk("rnd_passes", win_pass, n);
`ifdef FMA_SEQ_STALL_CNT_EN
      chk("rnd_stall", {16'b0, stall_cnt}, win_gap);
`endif
    end
    rnd_rdy = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
